// File: rtl/ws_acc_drain.sv
// Carry-save accumulator drain: holds the (sum, carry) feedback pair, resolves it on the
// last beat through a split carry-propagate adder and queues results. Optional: WS_ACC_FLUSH_EN.
module ws_acc_drain #(
    parameter int WIDTH     = 32,
    parameter int SPLIT     = 16,
    parameter int OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef WS_ACC_FLUSH_EN
    input  logic             acc_flush,
`endif
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_c,
    output logic             in_ready,
    output logic [WIDTH-1:0] s_fb,
    output logic [WIDTH-1:0] c_fb,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int HW = WIDTH - SPLIT;
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic             flush;
    logic             accept;
    logic             take_last;
    logic [SPLIT:0]   low_sum;

    logic             st1_valid;
    logic [SPLIT-1:0] st1_low;
    logic             st1_carry;
    logic [HW-1:0]    st1_s_hi;
    logic [HW-1:0]    st1_c_hi;

    logic [HW-1:0]    high;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;

    logic [WIDTH-1:0] mem [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;

`ifdef WS_ACC_FLUSH_EN
    assign flush = acc_flush;
`else
    assign flush = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign take_last = accept && in_last && !flush;
    assign low_sum   = {1'b0, in_s[SPLIT-1:0]} + {1'b0, in_c[SPLIT-1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Feedback pair: a flush or a last beat clears it so the next dot product starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_fb <= '0;
            c_fb <= '0;
        end else if (flush || take_last) begin
            s_fb <= '0;
            c_fb <= '0;
        end else if (accept) begin
            s_fb <= in_s;
            c_fb <= in_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_valid <= 1'b0;
            st1_low   <= '0;
            st1_carry <= 1'b0;
            st1_s_hi  <= '0;
            st1_c_hi  <= '0;
        end else begin
            st1_valid <= take_last;
            if (take_last) begin
                st1_low   <= low_sum[SPLIT-1:0];
                st1_carry <= low_sum[SPLIT];
                st1_s_hi  <= in_s[WIDTH-1:SPLIT];
                st1_c_hi  <= in_c[WIDTH-1:SPLIT];
            end
        end
    end

    // Second adder half resolves directly into the FIFO write port.
    assign high      = st1_s_hi + st1_c_hi + HW'(st1_carry);
    assign push_data = {high, st1_low};
    assign push      = st1_valid;
    assign pop       = (count != '0) && out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
        end
    end

    // Credits cover queued results plus the one in the adder; a pop only helps next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (int'(count_next) + int'(take_last)) < OUT_DEPTH;
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

endmodule
